// File: rtl/riscv_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit_if
// Bus bundle of the fetch unit: the instruction-memory request/response
// channel and the fetch-queue output toward decode.
//   req_valid/req_ready/req_addr : request channel (fetch -> memory)
//   rsp_valid/rsp_data           : in-order response, at most one per cycle
//   out_valid/out_ready          : fetch-queue head handshake (fetch -> decode)
//   out_pc/out_instr             : pc and instruction word of the queue head
// Modports: master = fetch unit side, slave = memory/decode environment side.
// ---------------------------------------------------------------------------
interface riscv_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_instr,
    input  req_ready, rsp_valid, rsp_data, out_ready
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_instr,
    output req_ready, rsp_valid, rsp_data, out_ready
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit
// Sequential instruction fetch with a credit-limited fetch queue and
// branch/trap redirect. Requests are issued only while queue occupancy plus
// kept in-flight requests leaves room, so every kept response has a slot.
// On redirect the queue is flushed and all in-flight requests are converted
// into discards, which drop the matching responses as they return.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   is_branch, branch_target    : branch redirect request and address
//   is_trap, trap_target        : trap redirect request and address (wins)
//   bus (master)                : memory request/response and decode output
//   fq_count                    : current fetch-queue occupancy
// FQ_DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module riscv_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        is_branch,
  input  logic                        is_trap,
  input  logic [XLEN-1:0]             branch_target,
  input  logic [XLEN-1:0]             trap_target,
  riscv_fetch_unit_if.master          bus,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  // Architectural state
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tail_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;

  // Queue storage
  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [XLEN-1:0] q_instr [FQ_DEPTH];

  // Per-cycle decisions
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            drop;
  logic            pop;
  logic            req_valid_c;
  logic            out_valid_c;
  logic [CW-1:0]   pending;
  logic [CW-1:0]   discard_redir;

  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    redirect      = is_branch | is_trap;
    target        = (is_trap ? trap_target : branch_target) & ~XLEN'(3);
    credit_ok     = (count + outstanding) < DEPTH_C;
    req_valid_c   = rst & ~redirect & credit_ok;
    issue         = req_valid_c & bus.req_ready;
    drop          = bus.rsp_valid & ~redirect & (discard != '0);
    push          = bus.rsp_valid & ~redirect & (discard == '0);
    out_valid_c   = (count != '0) & ~redirect;
    pop           = out_valid_c & bus.out_ready;
    // Everything in flight becomes a discard; a response returning in the
    // redirect cycle itself is one of those and is consumed immediately.
    pending       = discard + outstanding;
    discard_redir = (bus.rsp_valid && pending != '0) ? pending - CW'(1) : pending;
  end

  assign bus.req_valid = req_valid_c;
  assign bus.req_addr  = pc;
  assign bus.out_valid = out_valid_c;
  assign bus.out_pc    = q_pc[head_ptr];
  assign bus.out_instr = q_instr[head_ptr];
  assign fq_count      = count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      tail_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      head_ptr    <= '0;
      tail_ptr    <= '0;
    end else if (redirect) begin
      pc          <= target;
      tail_pc     <= target;
      count       <= '0;
      outstanding <= '0;
      discard     <= discard_redir;
      head_ptr    <= '0;
      tail_ptr    <= '0;
    end else begin
      if (issue) pc <= pc + STEP;
      outstanding <= outstanding + CW'(issue) - CW'(push);
      count       <= count + CW'(push) - CW'(pop);
      if (drop) discard <= discard - CW'(1);
      if (push) begin
        tail_pc  <= tail_pc + STEP;
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (pop) head_ptr <= head_ptr + PW'(1);
    end
  end

  // NOTE: the queue payload is deliberately left without reset; an entry is
  // only read once count marks it valid, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail_ptr]    <= tail_pc;
      q_instr[tail_ptr] <= bus.rsp_data;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_fetch_unit
// Self-checking bench for riscv_fetch_unit. A directed vector table covers
// sequential fetch, queue-full back-pressure, redirect with outstanding
// requests, trap priority with target alignment and pc wrap. Randomized
// traffic is then checked against a request-tagging reference model: each
// in-flight request carries a keep flag that a redirect clears, and kept
// responses land in a queue of {pc, instr} pairs.
// ---------------------------------------------------------------------------
module tb_riscv_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk;
  logic        rst;
  logic        is_branch;
  logic        is_trap;
  logic [31:0] branch_target;
  logic [31:0] trap_target;
  logic [2:0]  fq_count;

  riscv_fetch_unit_if #(.XLEN(XLEN)) bus ();

  riscv_fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .is_branch    (is_branch),
    .is_trap      (is_trap),
    .branch_target(branch_target),
    .trap_target  (trap_target),
    .bus          (bus),
    .fq_count     (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br, tr;
    logic [31:0] bt, tt;
    logic        rr, orr, go;
    logic        chk;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_ov;
    logic [31:0] e_op;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        keep;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fent_t;

  vec_t        tbl[$];
  mreq_t       mem_q[$];
  fent_t       fq[$];
  logic [31:0] m_pc;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic br, input logic tr, input logic [31:0] bt, input logic [31:0] tt,
                     input logic rr, input logic orr, input logic go,
                     input logic erv, input logic [31:0] era, input logic eov,
                     input logic [31:0] eop, input int ecnt);
    vec_t v;
    v.br = br; v.tr = tr; v.bt = bt; v.tt = tt;
    v.rr = rr; v.orr = orr; v.go = go; v.chk = 1'b1;
    v.e_rv = erv; v.e_ra = era; v.e_ov = eov; v.e_op = eop; v.e_cnt = 32'(ecnt);
    tbl.push_back(v);
  endtask

  // Entered just after a rising edge; drives inputs, checks at the falling
  // edge, advances the model and returns just after the next rising edge.
  task automatic step(input vec_t v);
    mreq_t       mr;
    logic        redir, e_rv, e_ov, rsp_now;
    logic [31:0] tgt;
    int          kept;
    is_branch     = v.br;
    is_trap       = v.tr;
    branch_target = v.bt;
    trap_target   = v.tt;
    bus.req_ready = v.rr;
    bus.out_ready = v.orr;
    rsp_now       = v.go && (mem_q.size() > 0);
    bus.rsp_valid = rsp_now;
    bus.rsp_data  = rsp_now ? instr_of(mem_q[0].addr) : $urandom();
    @(negedge clk);
    redir = v.br | v.tr;
    tgt   = (v.tr ? v.tt : v.bt) & 32'hFFFF_FFFC;
    kept  = 0;
    foreach (mem_q[i]) if (mem_q[i].keep) kept++;
    e_rv = !redir && (fq.size() + kept < DEPTH);
    e_ov = !redir && (fq.size() != 0);
    check("req_valid", 32'(bus.req_valid), 32'(e_rv));
    check("out_valid", 32'(bus.out_valid), 32'(e_ov));
    check("fq_count", 32'(fq_count), 32'(fq.size()));
    if (e_rv) check("req_addr", bus.req_addr, m_pc);
    if (e_ov) begin
      check("out_pc", bus.out_pc, fq[0].pc);
      check("out_instr", bus.out_instr, fq[0].instr);
    end
    if (v.chk) begin
      check("tbl_req_valid", 32'(bus.req_valid), 32'(v.e_rv));
      check("tbl_out_valid", 32'(bus.out_valid), 32'(v.e_ov));
      check("tbl_fq_count", 32'(fq_count), v.e_cnt);
      if (v.e_rv) check("tbl_req_addr", bus.req_addr, v.e_ra);
      if (v.e_ov) check("tbl_out_pc", bus.out_pc, v.e_op);
    end
    mr = '{addr: 32'h0, keep: 1'b0};
    if (rsp_now) begin
      mr = mem_q[0];
      mem_q.delete(0);
    end
    if (e_ov && v.orr) fq.delete(0);
    if (rsp_now && !redir && mr.keep) fq.push_back('{pc: mr.addr, instr: instr_of(mr.addr)});
    if (redir) begin
      fq.delete();
      foreach (mem_q[i]) mem_q[i].keep = 1'b0;
      m_pc = tgt;
    end else if (e_rv && v.rr) begin
      mem_q.push_back('{addr: m_pc, keep: 1'b1});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges; the memory is reset along with the unit.
  task automatic async_reset();
    #2;
    rst           = 1'b0;
    bus.rsp_valid = 1'b0;
    is_branch     = 1'b0;
    is_trap       = 1'b0;
    #1;
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fq_count", 32'(fq_count), 32'd0);
    fq.delete();
    mem_q.delete();
    m_pc = RPC;
    @(posedge clk);
    #1;
    check("rst_hold_req_addr", bus.req_addr, RPC);
    rst = 1'b1;
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    m_pc     = RPC;
    rst = 1'b0; is_branch = 1'b0; is_trap = 1'b0;
    branch_target = '0; trap_target = '0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.out_ready = 1'b0;

    // Sequential fetch, one-cycle memory, decode always ready
    add(0,0,0,0, 1,1,1, 1,32'h00,0,32'h0,0);
    add(0,0,0,0, 1,1,1, 1,32'h04,0,32'h0,0);
    add(0,0,0,0, 1,1,1, 1,32'h08,1,32'h0,1);
    add(0,0,0,0, 1,1,1, 1,32'h0C,1,32'h4,1);
    add(0,0,0,0, 1,1,1, 1,32'h10,1,32'h8,1);
    // Decode stalls: credits run out with the queue full
    add(0,0,0,0, 1,0,1, 1,32'h14,1,32'hC,1);
    add(0,0,0,0, 1,0,1, 1,32'h18,1,32'hC,2);
    add(0,0,0,0, 1,0,1, 0,32'h0, 1,32'hC,3);
    add(0,0,0,0, 1,0,1, 0,32'h0, 1,32'hC,4);
    add(0,0,0,0, 1,0,1, 0,32'h0, 1,32'hC,4);
    add(0,0,0,0, 1,1,1, 0,32'h0, 1,32'hC,4);
    add(0,0,0,0, 1,1,1, 1,32'h1C,1,32'h10,3);
    // Branch and trap together, misaligned targets: trap wins, low bits cleared
    add(1,1,32'h202,32'h83, 1,1,1, 0,32'h0,0,32'h0,2);
    add(0,0,0,0, 1,1,1, 1,32'h80,0,32'h0,0);
    add(0,0,0,0, 1,1,1, 1,32'h84,0,32'h0,0);
    add(0,0,0,0, 1,1,1, 1,32'h88,1,32'h80,1);
    // Two requests outstanding at 0x10/0x14, then branch to 0x100
    add(1,0,32'h10,0, 1,1,1, 0,32'h0,0,32'h0,1);
    add(0,0,0,0, 1,1,0, 1,32'h10,0,32'h0,0);
    add(0,0,0,0, 1,1,0, 1,32'h14,0,32'h0,0);
    add(1,0,32'h100,0, 1,1,0, 0,32'h0,0,32'h0,0);
    add(0,0,0,0, 1,1,1, 1,32'h100,0,32'h0,0);
    add(0,0,0,0, 1,1,1, 1,32'h104,0,32'h0,0);
    add(0,0,0,0, 1,1,1, 1,32'h108,0,32'h0,0);
    add(0,0,0,0, 1,1,1, 1,32'h10C,1,32'h100,1);
    // pc wrap at the top of the address space
    add(1,0,32'hFFFF_FFFC,0, 1,1,1, 0,32'h0,0,32'h0,1);
    add(0,0,0,0, 1,1,0, 1,32'hFFFF_FFFC,0,32'h0,0);
    add(0,0,0,0, 1,1,0, 1,32'h0,0,32'h0,0);
    add(0,0,0,0, 0,1,1, 1,32'h4,0,32'h0,0);
    add(0,0,0,0, 0,1,1, 1,32'h4,0,32'h0,0);
    add(0,0,0,0, 0,1,1, 1,32'h4,1,32'hFFFF_FFFC,1);
    add(0,0,0,0, 0,1,1, 1,32'h4,1,32'h0,1);

    #1;
    check("reset_req_valid", 32'(bus.req_valid), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_fq_count", 32'(fq_count), 32'd0);
    check("reset_req_addr", bus.req_addr, RPC);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Fill the queue with decode stalled, then reset asynchronously
    v = '{default: '0};
    v.rr = 1'b1; v.go = 1'b1;
    for (int i = 0; i < 5; i++) step(v);
    check("prefill_nonempty", 32'(fq.size() != 0), 32'd1);
    async_reset();
    v.orr = 1'b1;
    for (int i = 0; i < 4; i++) step(v);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      v     = '{default: '0};
      v.br  = ($urandom_range(15) == 0);
      v.tr  = ($urandom_range(31) == 0);
      v.bt  = $urandom();
      v.tt  = $urandom();
      if ($urandom_range(3) == 0) v.bt = 32'hFFFF_FFF0 | (v.bt & 32'hF);
      v.rr  = ($urandom_range(3) != 0) && (mem_q.size() < 6);
      v.orr = ($urandom_range(3) != 0);
      v.go  = ($urandom_range(3) != 0);
      step(v);
      if ($urandom_range(399) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
